// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: word array read at request acceptance, a fixed-latency
// valid-tagged delay pipeline, and an in-order output FIFO protected by an occupancy credit.
module instr_mem_responder #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [DATAWIDTH-1:0] req_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATAWIDTH-1:0] rsp_instr,
    output logic [DATAWIDTH-1:0] rsp_addr,
    output logic [1:0]           rsp_fault,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [DATAWIDTH-1:0] wr_addr,
    input  logic [DATAWIDTH-1:0] wr_data
);
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FDEPTH = LATENCY + 1;
    localparam int unsigned PW     = $clog2(FDEPTH);
    localparam int unsigned CW     = $clog2(FDEPTH + 1);
    localparam int unsigned NSTAGE = (LATENCY > 1) ? LATENCY - 1 : 1;

    localparam logic [DATAWIDTH-1:0] NOP            = DATAWIDTH'(32'h0000_0013);
    localparam logic [1:0]           FAULT_MISALIGN = 2'b01;
    localparam logic [1:0]           FAULT_RANGE    = 2'b10;

    typedef struct packed {
        logic [DATAWIDTH-1:0] instr;
        logic [DATAWIDTH-1:0] addr;
        logic [1:0]           fault;
    } rsp_t;

    logic [DATAWIDTH-1:0] mem_q [DEPTH];

    logic [NSTAGE-1:0] stage_vld_q, stage_vld_d;
    rsp_t              stage_q [NSTAGE];
    rsp_t              stage_d [NSTAGE];

    rsp_t              fifo_q [FDEPTH];
    rsp_t              fifo_d [FDEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     occ_q, occ_d;

    logic [DATAWIDTH-1:0] req_word;
    logic [DATAWIDTH-1:0] wr_word;
    logic                 accept;
    logic                 pop;
    logic                 push;
    logic                 clear;
    rsp_t                 ingress;
    rsp_t                 push_data;
    rsp_t                 head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign req_word  = req_addr >> 2;
    assign wr_word   = wr_addr >> 2;
    assign clear     = rst || flush;
    // Occupancy counts every accepted-but-unconsumed response, so the FIFO can never overflow.
    assign req_ready = !rst && !flush && (occ_q < CW'(FDEPTH));
    assign accept    = req_valid && req_ready;

    assign rsp_valid = (cnt_q != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign head      = fifo_q[rd_ptr_q];
    assign rsp_instr = rsp_valid ? head.instr : '0;
    assign rsp_addr  = rsp_valid ? head.addr  : '0;
    assign rsp_fault = rsp_valid ? head.fault : '0;

    // The array is sampled into the first register on the acceptance edge, so a
    // same-edge loader write to that word is not yet visible.
    always_comb begin
        ingress      = '0;
        ingress.addr = req_addr;
        if (req_addr[1:0] != 2'b00) begin
            ingress.fault = FAULT_MISALIGN;
            ingress.instr = NOP;
        end else if (req_word >= DATAWIDTH'(DEPTH)) begin
            ingress.fault = FAULT_RANGE;
            ingress.instr = NOP;
        end else begin
            ingress.instr = mem_q[req_word[AW-1:0]];
        end
    end

    always_comb begin
        stage_vld_d    = stage_vld_q;
        stage_d        = stage_q;
        stage_vld_d[0] = accept;
        stage_d[0]     = ingress;
        for (int unsigned i = 1; i < NSTAGE; i++) begin
            stage_vld_d[i] = stage_vld_q[i-1];
            stage_d[i]     = stage_q[i-1];
        end
        if (clear) begin
            stage_vld_d = '0;
        end
    end

    // With LATENCY=1 the array read lands directly in the FIFO.
    assign push      = (LATENCY == 1) ? accept  : stage_vld_q[NSTAGE-1];
    assign push_data = (LATENCY == 1) ? ingress : stage_q[NSTAGE-1];

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_data;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        occ_d = occ_q + CW'(accept) - CW'(pop);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            occ_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && (wr_word < DATAWIDTH'(DEPTH))) begin
            mem_q[wr_word[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        stage_vld_q <= stage_vld_d;
        stage_q     <= stage_d;
        fifo_q      <= fifo_d;
        wr_ptr_q    <= wr_ptr_d;
        rd_ptr_q    <= rd_ptr_d;
        cnt_q       <= cnt_d;
        occ_q       <= occ_d;
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized scoreboard bench for instr_mem_responder: a word-array/queue reference model
// predicts every response, its earliest visible cycle, and the request-ready credit.
module tb_instr_mem_responder;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_addr  = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_instr;
    logic [DW-1:0] rsp_addr;
    logic [1:0]    rsp_fault;
    logic          flush     = 1'b0;
    logic          wr_en     = 1'b0;
    logic [DW-1:0] wr_addr   = '0;
    logic [DW-1:0] wr_data   = '0;

    instr_mem_responder #(
        .DATAWIDTH(DW),
        .DEPTH    (DEPTH),
        .LATENCY  (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr),
        .rsp_addr (rsp_addr),
        .rsp_fault(rsp_fault),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [1:0]  fault;
        int          rdy;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [DEPTH];
    int          cyc     = 0;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    function automatic exp_t predict(input logic [31:0] a, input int now);
        exp_t e;
        e.addr = a;
        e.rdy  = now + int'(LAT);
        if (a[1:0] != 2'b00) begin
            e.fault = 2'b01;
            e.instr = NOP;
        end else if ((a >> 2) >= DEPTH) begin
            e.fault = 2'b10;
            e.instr = NOP;
        end else begin
            e.fault = 2'b00;
            e.instr = ref_mem[a >> 2];
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 19);
        if (r < 14) return 32'($urandom_range(0, DEPTH - 1)) << 2;
        else if (r < 17) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        else return 32'($urandom_range(DEPTH, DEPTH + 4095)) << 2;
    endfunction

    always @(posedge clk) cyc++;

    // Cycle-level scoreboard: a response is due once its arrival cycle has passed,
    // and the credit is free while fewer than LAT+1 responses are owed.
    always @(negedge clk) begin : monitor
        logic exp_v;
        logic exp_rdy;
        exp_t h;
        exp_v   = (sb.size() > 0) && (sb[0].rdy <= cyc);
        exp_rdy = !rst && !flush && (sb.size() < int'(LAT + 1));
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (exp_v) begin
            h = sb[0];
            if (rsp_valid) begin
                check("rsp_instr", rsp_instr, h.instr);
                check("rsp_addr", rsp_addr, h.addr);
                check("rsp_fault", 32'(rsp_fault), 32'(h.fault));
            end
            if (rsp_ready) void'(sb.pop_front());
        end
        if (rst || flush) sb.delete();
        else if (req_valid && exp_rdy) sb.push_back(predict(req_addr, cyc));
        if (wr_en && ((wr_addr >> 2) < DEPTH)) ref_mem[wr_addr >> 2] = wr_data;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a);
        int n;
        n         = 0;
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("issue_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin : stimulus
        int n;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_instr", rsp_instr, 32'd0);
        check("reset_rsp_addr", rsp_addr, 32'd0);
        check("reset_rsp_fault", 32'(rsp_fault), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < int'(DEPTH); i++) begin
            wr_en   = 1'b1;
            wr_addr = 32'(i) << 2;
            wr_data = $urandom;
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        write_word(32'h0, 32'h00A0_0093);
        write_word(32'h4, 32'h0010_8113);
        write_word(32'h8, 32'h0021_01B3);
        write_word(32'hC, 32'hFE00_0EE3);
        write_word(32'h10, 32'h1111_1111);

        rsp_ready = 1'b1;
        issue(32'h0);
        issue(32'h4);
        issue(32'h8);
        issue(32'hC);
        idle(6);

        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (req_ready) n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("bp_accept_count", 32'(n), 32'd3);
        rsp_ready = 1'b1;
        idle(8);

        issue(32'h6);
        issue(32'h1002);
        issue(32'h1000);
        idle(6);

        rsp_ready = 1'b0;
        issue(32'h0);
        issue(32'h4);
        flush = 1'b1;
        idle(1);
        flush     = 1'b0;
        rsp_ready = 1'b1;
        issue(32'h8);
        idle(6);

        wr_en   = 1'b1;
        wr_addr = 32'h10;
        wr_data = 32'h2222_2222;
        issue(32'h10);
        wr_en = 1'b0;
        issue(32'h10);
        idle(6);

        for (int k = 0; k < 3000; k++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = rand_addr();
            rsp_ready = ($urandom_range(0, 3) != 0);
            wr_en     = ($urandom_range(0, 9) == 0);
            wr_addr   = rand_addr();
            wr_data   = $urandom;
            flush     = ($urandom_range(0, 49) == 0);
            rst       = (k >= 1500 && k < 1502);
            if (rst) wr_en = 1'b0;
            @(posedge clk);
            #1;
        end

        req_valid = 1'b0;
        wr_en     = 1'b0;
        flush     = 1'b0;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Instruction-memory responder: the far end of the fetch interface driven by the program counter.
- Accepts word fetch requests (address, valid/ready), reads a synchronous word array, and returns the instruction in order after a fixed pipeline latency.
- Buffers responses under decode back-pressure, flags misaligned/out-of-range fetches, supports pipeline flush on redirect, and has a loader write port.

Parameters:
DATAWIDTH, 32, instruction/address width
DEPTH, 1024, number of 32-bit words in the array
LATENCY, 2, cycles from request acceptance to earliest rsp_valid; legal 1..4

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req_valid  input  1  fetch request present
req_ready  output  1  responder can accept a request this cycle
req_addr  input  DATAWIDTH  byte address of fetch
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response this cycle
rsp_instr  output  DATAWIDTH  fetched instruction
rsp_addr  output  DATAWIDTH  byte address the response belongs to
rsp_fault  output  2  00 ok, 01 misaligned, 10 out of range
flush  input  1  discard all outstanding/buffered responses
wr_en  input  1  loader write strobe
wr_addr  input  DATAWIDTH  byte address of loader write (bits [1:0] ignored)
wr_data  input  DATAWIDTH  loader write data

Behaviour:
- Reset: rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_fault=00, pipeline valids cleared, occupancy=0, FIFO pointers=0. Array contents not reset. req_ready=0 while rst high.
- Acceptance: request taken on a rising edge where req_valid & req_ready.
- req_ready = !rst & !flush & (occupancy < LATENCY+1).
  - occupancy = in-flight stages + buffered responses.
  - occupancy +1 on accept, -1 on rsp_valid & rsp_ready; both in one cycle leaves it unchanged.
- Latency: request accepted at edge t with empty output FIFO → rsp_valid high in the cycle following edge t+LATENCY-1.
  - LATENCY=1: response visible the cycle after acceptance.
  - Sustained throughput is 1/cycle with rsp_ready held high.
- Array read on the acceptance edge; remaining LATENCY-1 cycles are a valid-tagged delay pipeline carrying instr/addr/fault.
- Output FIFO:
  - Depth LATENCY+1; rsp_* driven from its head.
  - Pipeline never stalls; the credit rule guarantees FIFO space.
  - Strictly in-order; no reordering or dropping except on flush.
- Fault rules, evaluated at acceptance:
  - req_addr[1:0]!=0 → fault 01.
  - Else req_addr[DATAWIDTH-1:2] >= DEPTH → fault 10.
  - Misaligned has priority over out-of-range.
  - A faulted response returns rsp_instr=0x00000013 (NOP) and rsp_addr=req_addr, with the same latency as a good fetch.
- Flush:
  - On a flush edge, all pipeline valids and FIFO entries are cleared and occupancy is 0.
  - rsp_valid=0 in the following cycle.
  - A rsp handshake in the flush cycle still completes.
  - No request is accepted in the flush cycle (req_ready=0).
  - The first request after flush sees full LATENCY.
- Loader write:
  - On an edge with wr_en, word wr_addr[DATAWIDTH-1:2] is written.
  - Indices >= DEPTH are ignored silently.
  - Write and fetch of the same word on the same edge: fetch returns OLD data (read-before-write).
- Back-pressure: while rsp_valid & !rsp_ready, rsp_* are held stable; in-flight responses accumulate in the FIFO.
- rst mid-operation: same as reset; outstanding responses are lost, array is unchanged.

Test Plan:
- Reset/idle: assert rst 2 cycles, LATENCY=2 → rsp_valid=0, rsp_fault=00; req_ready=1 the first cycle after rst drops.
- Streaming: load 0x00A00093@0x0, 0x00108113@0x4, 0x002101B3@0x8, 0xFE000EE3@0xC; request 0x0,0x4,0x8,0xC back-to-back with rsp_ready=1 → four responses on consecutive cycles, first 2 cycles after the first acceptance, rsp_addr matching, fault 00.
- Back-pressure: rsp_ready=0 with req_valid held → exactly 3 requests accepted, then req_ready=0. Release rsp_ready → 3 in-order responses, and req_ready rises the cycle after the first pop.
- Faults: request 0x6 → fault 01, instr 0x00000013. Request 0x1002 with DEPTH=1024 → fault 01 (priority). Request 0x1000 → fault 10, instr 0x00000013.
- Flush: accept 0x0,0x4, assert flush the next cycle → no response for either; then request 0x8 → response 0x002101B3 exactly LATENCY cycles later.
- Write collision: word 0x10=0x11111111; same edge wr_en (0x10 ← 0x22222222) and fetch 0x10 → response 0x11111111. A fetch on the next cycle → 0x22222222.
